lmt_restore: RTL and testbench

Bus-initiator engine that copies the LMT snapshot back into the MR data-memory region. On `start` it reads each LMT word over the peripheral bus as a master and writes it through the data-memory write port as full 16-bit stores. It is the writer counterpart of the LMT mirror, which snoops MR stores and serves LMT reads. The engine sits beside the CPU and shares the data-memory write port through a grant signal.

---
 rtl/lmt_pkg.sv | 33 +++
 rtl/lmt_chksum.sv | 23 ++
 rtl/lmt_restore.sv | 115 +++++++++++
 tb/tb_lmt_restore.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lmt_pkg.sv
// Shared types and defaults for the LMT snapshot mirror and restore engine.
package lmt_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned PADDR_W = 14;
  localparam int unsigned IDX_W   = 4;

  localparam logic [15:0] LMT_BASE_DEF = 16'h0040;
  localparam logic [15:0] MR_BASE_DEF  = 16'h0230;
  localparam int unsigned MEM_SIZE_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Peripheral word address of LMT word idx (low 14 bits of the 16-bit sum).
  function automatic logic [PADDR_W-1:0] lmt_addr(input logic [15:0] base,
                                                  input logic [IDX_W-1:0] idx);
    logic [15:0] sum;
    sum = base + 16'(idx);
    return sum[PADDR_W-1:0];
  endfunction

  // Data-memory byte address of MR word idx; always word aligned.
  function automatic logic [15:0] mr_addr(input logic [15:0] base,
                                          input logic [IDX_W-1:0] idx);
    return base + {11'd0, idx, 1'b0};
  endfunction

endpackage

// File: rtl/lmt_chksum.sv
// XOR accumulator over restored words; only built with LMT_RESTORE_CHKSUM_EN.
`ifdef LMT_RESTORE_CHKSUM_EN
module lmt_chksum
  import lmt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] acc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc ^ din;
    end
  end

endmodule
`endif

// File: rtl/lmt_restore.sv
// Copies the LMT snapshot back into MR data memory as word stores.
// Optional XOR checksum output under LMT_RESTORE_CHKSUM_EN.
module lmt_restore
  import lmt_pkg::*;
#(
  parameter logic [15:0] LMT_BASE = LMT_BASE_DEF,
  parameter logic [15:0] MR_BASE  = MR_BASE_DEF,
  parameter int unsigned MEM_SIZE = MEM_SIZE_DEF
) (
  input  logic               mclk,
  input  logic               puc_rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [PADDR_W-1:0] per_addr,
  output logic               per_en,
  output logic [1:0]         per_we,
  output logic [DATA_W-1:0]  per_din,
  input  logic [DATA_W-1:0]  per_dout,
  output logic [15:0]        d_addr,
  output logic [1:0]         w_en,
  output logic [DATA_W-1:0]  dmem_din,
  input  logic               dmem_gnt
`ifdef LMT_RESTORE_CHKSUM_EN
  ,
  output logic [DATA_W-1:0]  chksum
`endif
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(MEM_SIZE - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;

  assign per_we  = 2'b00;
  assign per_din = '0;

  // Outputs are registered alongside the state so each reflects the state it belongs to.
  // dmem_din doubles as the captured read word and holds through grant stalls.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state    <= IDLE;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      per_addr <= '0;
      per_en   <= 1'b0;
      d_addr   <= '0;
      w_en     <= 2'b00;
      dmem_din <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          idx <= '0;
          if (start) begin
            state    <= RD;
            busy     <= 1'b1;
            per_en   <= 1'b1;
            per_addr <= lmt_addr(LMT_BASE, '0);
          end
        end
        RD: begin
          state    <= WR;
          per_en   <= 1'b0;
          per_addr <= '0;
          w_en     <= 2'b11;
          d_addr   <= mr_addr(MR_BASE, idx);
          dmem_din <= per_dout;
        end
        WR: begin
          if (dmem_gnt) begin
            w_en     <= 2'b00;
            d_addr   <= '0;
            dmem_din <= '0;
            if (idx == LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state    <= RD;
              idx      <= idx + IDX_W'(1);
              per_en   <= 1'b1;
              per_addr <= lmt_addr(LMT_BASE, idx + IDX_W'(1));
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef LMT_RESTORE_CHKSUM_EN
  logic chk_clr;
  logic chk_en;

  assign chk_clr = (state == IDLE) && start;
  assign chk_en  = (state == WR) && dmem_gnt;

  lmt_chksum u_chksum (
    .clk (mclk),
    .rst (puc_rst),
    .clr (chk_clr),
    .en  (chk_en),
    .din (dmem_din),
    .acc (chksum)
  );
`endif

endmodule

// File: tb/tb_lmt_restore.sv
// Randomized bench for lmt_restore with a schedule-based reference model.
module tb_lmt_restore;
  import lmt_pkg::*;

  localparam int N = 16;

  logic        mclk = 1'b0;
  logic        puc_rst, start, dmem_gnt;
  logic        busy, done, per_en;
  logic [13:0] per_addr;
  logic [1:0]  per_we, w_en;
  logic [15:0] per_din, per_dout, d_addr, dmem_din;

  logic        o_start;
  logic        o_busy, o_done, o_per_en;
  logic [13:0] o_per_addr;
  logic [1:0]  o_per_we, o_w_en;
  logic [15:0] o_per_din, o_per_dout, o_d_addr, o_dmem_din;
`ifdef LMT_RESTORE_CHKSUM_EN
  logic [15:0] chksum, o_chksum;
`endif

  always #5 mclk = ~mclk;

  lmt_restore u_dut (
    .mclk(mclk), .puc_rst(puc_rst), .start(start), .busy(busy), .done(done),
    .per_addr(per_addr), .per_en(per_en), .per_we(per_we), .per_din(per_din),
    .per_dout(per_dout), .d_addr(d_addr), .w_en(w_en), .dmem_din(dmem_din),
    .dmem_gnt(dmem_gnt)
`ifdef LMT_RESTORE_CHKSUM_EN
    , .chksum(chksum)
`endif
  );

  lmt_restore #(.MEM_SIZE(1)) u_one (
    .mclk(mclk), .puc_rst(puc_rst), .start(o_start), .busy(o_busy), .done(o_done),
    .per_addr(o_per_addr), .per_en(o_per_en), .per_we(o_per_we), .per_din(o_per_din),
    .per_dout(o_per_dout), .d_addr(o_d_addr), .w_en(o_w_en), .dmem_din(o_dmem_din),
    .dmem_gnt(1'b1)
`ifdef LMT_RESTORE_CHKSUM_EN
    , .chksum(o_chksum)
`endif
  );

  // LMT contents served on the peripheral bus; garbage when not enabled.
  logic [15:0] lmt [N];
  logic [13:0] lmt_off;
  always_comb begin
    lmt_off  = per_addr - 14'(LMT_BASE_DEF);
    per_dout = per_en ? lmt[lmt_off[3:0]] : 16'hDEAD;
  end

  int vectors = 0;
  int miscompares = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  // Reference model: transfer timeline from accept cycle, words committed, stall cycles.
  int          cyc = 0;
  bit          chk_en = 1'b0;
  bit          active = 1'b0;
  int          t0 = 0, k = 0, stall = 0, rel;
  logic [15:0] exp_chk = '0;
  logic        e_busy, e_done, e_pen;
  logic [1:0]  e_wen;
  logic [13:0] e_paddr;
  logic [15:0] e_daddr, e_ddin;

  int          done_seen = 0, writes_seen = 0, last_done_rel = 0;
  int          busy_low_run = 0, last_gap = 0;
  logic [15:0] mr_dut [N];
  logic [15:0] wr_off;

  always @(posedge mclk) cyc <= cyc + 1;

  always @(negedge mclk) begin
    if (chk_en) begin
      e_busy = 1'b0; e_done = 1'b0; e_pen = 1'b0; e_wen = 2'b00;
      e_paddr = '0; e_daddr = '0; e_ddin = '0;
      rel = cyc - t0 - stall;
      if (active) begin
        if (k < N && rel == 2*k+1) begin
          e_busy = 1'b1; e_pen = 1'b1; e_paddr = 14'(LMT_BASE_DEF + 16'(k));
        end else if (k < N && rel == 2*k+2) begin
          e_busy = 1'b1; e_wen = 2'b11;
          e_daddr = MR_BASE_DEF + 16'(2*k); e_ddin = lmt[k];
        end else if (k == N && rel == 2*N+1) begin
          e_done = 1'b1;
        end
      end
      check("cyc_ctrl", 64'({busy, done, per_en, per_we, w_en}),
            64'({e_busy, e_done, e_pen, 2'b00, e_wen}));
      check("cyc_addr", 64'({per_addr, d_addr}), 64'({e_paddr, e_daddr}));
      check("cyc_data", 64'({per_din, dmem_din}), 64'({16'h0000, e_ddin}));
`ifdef LMT_RESTORE_CHKSUM_EN
      check("cyc_chksum", 64'(chksum), 64'(exp_chk));
`endif
      if (w_en == 2'b11 && dmem_gnt) begin
        writes_seen++;
        wr_off = (d_addr - MR_BASE_DEF) >> 1;
        mr_dut[wr_off[3:0]] = dmem_din;
      end
      if (done) begin
        done_seen++;
        last_done_rel = cyc - t0;
      end
      if (!busy) busy_low_run++;
      else begin
        if (busy_low_run > 0) last_gap = busy_low_run;
        busy_low_run = 0;
      end
      if (active && e_wen != 2'b00) begin
        if (dmem_gnt) begin
          exp_chk = exp_chk ^ lmt[k];
          k++;
        end else begin
          stall++;
        end
      end
      if (active && e_done) active = 1'b0;
      else if (!active && start && !puc_rst) begin
        active = 1'b1; t0 = cyc; k = 0; stall = 0; exp_chk = '0;
      end
      if (puc_rst) begin
        active = 1'b0; exp_chk = '0;
      end
    end
  end

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0;
    int n;
    d0 = done_seen;
    n = 0;
    while (done_seen == d0 && n < budget) begin
      step();
      n++;
    end
    if (done_seen == d0) check(name, 64'(0), 64'(1));
  endtask

  task automatic clear_mr();
    for (int i = 0; i < N; i++) mr_dut[i] = 16'hFFFF;
  endtask

  int d0, w0, rst_at, n;

  initial begin
    puc_rst = 1'b1; start = 1'b0; dmem_gnt = 1'b1;
    o_start = 1'b0; o_per_dout = 16'hBEEF;
    for (int i = 0; i < N; i++) lmt[i] = 16'h0005;
    step();
    chk_en = 1'b1;
    step();
    puc_rst = 1'b0;
    step();

    // All words 5, grant always high.
    clear_mr(); w0 = writes_seen;
    pulse_start();
    wait_done(100, "t1_timeout");
    check("t1_done_cycle", 64'(last_done_rel), 64'd33);
    check("t1_writes", 64'(writes_seen - w0), 64'd16);
    for (int i = 0; i < N; i++) check("t1_mr_word", 64'(mr_dut[i]), 64'h0005);
`ifdef LMT_RESTORE_CHKSUM_EN
    check("t1_chksum", 64'(chksum), 64'h0);
`endif
    step();

    // Grant low for 3 cycles on word 4.
    for (int i = 0; i < N; i++) lmt[i] = 16'h1000 + 16'(i);
    clear_mr();
    pulse_start();
    repeat (9) step();
    dmem_gnt = 1'b0;
    step(); step();
    @(negedge mclk);
    check("t2_held_write", 64'({w_en, d_addr, dmem_din}), 64'({2'b11, 16'h0238, 16'h1004}));
    step();
    dmem_gnt = 1'b1;
    wait_done(100, "t2_timeout");
    check("t2_done_cycle", 64'(last_done_rel), 64'd36);
    for (int i = 0; i < N; i++) check("t2_mr_word", 64'(mr_dut[i]), 64'(16'h1000 + 16'(i)));
`ifdef LMT_RESTORE_CHKSUM_EN
    check("t2_chksum", 64'(chksum), 64'h0);
`endif
    step();

    // Extra start pulses mid-transfer are ignored.
    d0 = done_seen; w0 = writes_seen;
    pulse_start();
    repeat (4) step();
    pulse_start();
    repeat (14) step();
    pulse_start();
    wait_done(100, "t3_timeout");
    repeat (40) step();
    check("t3_done_count", 64'(done_seen - d0), 64'd1);
    check("t3_writes", 64'(writes_seen - w0), 64'd16);

    // Reset during the read of word 4.
    d0 = done_seen; w0 = writes_seen;
    pulse_start();
    repeat (8) step();
    puc_rst = 1'b1;
    step();
    puc_rst = 1'b0;
    @(negedge mclk);
    check("t4_outputs_after_rst", 64'({busy, done, per_en, w_en, per_addr, d_addr}), 64'd0);
    repeat (30) step();
    check("t4_writes", 64'(writes_seen - w0), 64'd4);
    check("t4_no_done", 64'(done_seen - d0), 64'd0);
    pulse_start();
    wait_done(100, "t4_restart_timeout");
    check("t4_restart_done_cycle", 64'(last_done_rel), 64'd33);
    step();

    // Start held high: back-to-back transfers.
    start = 1'b1;
    wait_done(100, "t5_first_timeout");
    wait_done(100, "t5_second_timeout");
    start = 1'b0;
    check("t5_busy_gap", 64'(last_gap), 64'd2);
    check("t5_second_done_cycle", 64'(last_done_rel), 64'd33);
    repeat (3) step();

    // Randomized transfers: random data, grant, stray starts, occasional reset.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++)
        lmt[i] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      d0 = done_seen;
      pulse_start();
      rst_at = (it % 5 == 2) ? int'($urandom_range(2, 30)) : -1;
      n = 0;
      while (done_seen == d0 && n < 300) begin
        dmem_gnt = ($urandom_range(0, 3) != 0);
        start    = ($urandom_range(0, 5) == 0);
        puc_rst  = (n == rst_at);
        step();
        n++;
        if (n - 1 == rst_at) break;
      end
      puc_rst = 1'b0; start = 1'b0; dmem_gnt = 1'b1;
      if (rst_at < 0) check("rand_done", 64'(done_seen - d0), 64'd1);
      n = 0;
      while (active && n < 300) begin
        step();
        n++;
      end
      step(); step();
    end

    // Single-word instance.
    o_start = 1'b1;
    step();
    o_start = 1'b0;
    @(negedge mclk);
    check("one_read", 64'({o_per_en, o_per_addr, o_busy}), 64'({1'b1, 14'h0040, 1'b1}));
    step();
    @(negedge mclk);
    check("one_write", 64'({o_w_en, o_d_addr, o_dmem_din}), 64'({2'b11, 16'h0230, 16'hBEEF}));
    step();
    @(negedge mclk);
    check("one_done", 64'({o_done, o_busy, o_w_en}), 64'({1'b1, 1'b0, 2'b00}));
`ifdef LMT_RESTORE_CHKSUM_EN
    step();
    @(negedge mclk);
    check("one_chksum", 64'(o_chksum), 64'hBEEF);
`endif
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
